freq_gate_ctrl: RTL
===================

FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz; legal range 1000..2^31, multiple of 1000.
REQ-002 Port clk_clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port reset_reset  input  1  asynchronous, active-high reset.
REQ-004 Port sig_in  input  1  measured signal, asynchronous to clk_clk.
REQ-005 Port run  input  1  1 = measure continuously; 0 = stop.
REQ-006 Port gate_sel  input  2  gate time: 0=1 ms, 1=10 ms, 2=100 ms, 3=1 s.
REQ-007 Port freq  output  32  last measured frequency in Hz; drives the Nios freq PIO.
REQ-008 Port freq_en  output  1  level, 1 = freq holds a valid result; drives the Nios freq_en PIO.
REQ-009 Port freq_upd  output  1  one-cycle pulse when freq takes a new value.
REQ-010 Port busy  output  1  1 while a gate window is open.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchroniser followed by a rising-edge detector; each detected edge SHALL be one event.
REQ-012 Gate length SHALL be G = CLK_HZ/1000 * {1,10,100,1000}[gate_sel] clock cycles.
REQ-013 FSM states SHALL be IDLE and GATE only.
REQ-014 In IDLE with run=1, the next cycle SHALL enter GATE with the gate counter at G-1 and the event count at 0.
REQ-015 In GATE, the gate counter SHALL decrement each cycle, and the 32-bit event count SHALL increment on each event.
REQ-016 The cycle in which the gate counter equals 0 is the terminal cycle; an event in that cycle SHALL count in the ending window.
REQ-017 At the terminal cycle with run=1, the count (including any terminal-cycle event) SHALL be latched as raw, and a new window SHALL start the next cycle with counter G-1 and count 0; there SHALL be no dead cycle.
REQ-018 Scaling SHALL be one registered stage: freq = raw * {1000,100,10,1}[gate_sel latched at window start].
REQ-019 Multiplication SHALL use shift-add only, no DSP multiplier; the product always fits in 32 bits (count <= G/2).
REQ-020 freq and freq_upd SHALL update 2 cycles after the terminal cycle, and freq_en SHALL become 1 in that same cycle.
REQ-021 freq SHALL hold its value between updates.
REQ-022 run=0 in any GATE cycle SHALL abort the window: return to IDLE next cycle, discard the count, no update; freq and freq_en SHALL hold.
REQ-023 A gate_sel change while in GATE SHALL abort the window, clear freq_en, and restart a new window at the new G the next cycle (if run=1).
REQ-024 A gate_sel change in IDLE SHALL clear freq_en.
REQ-025 If a terminal cycle and a gate_sel change coincide, the gate_sel change SHALL win: no latch and no update.
REQ-026 busy SHALL be 1 exactly when state = GATE.

Reset
REQ-027 While reset_reset=1, the block SHALL set: state=IDLE, freq=0, freq_en=0, freq_upd=0, busy=0, counters=0, synchroniser flops=0, scale pipeline cleared.
REQ-028 Reset asserted mid-window SHALL discard the window; after release, measurement SHALL restart from IDLE per REQ-014.
REQ-029 The edge detector SHALL NOT report an edge on the first cycle after reset release.

Structure
REQ-030 A shared package freq_meter_pkg SHALL hold the state enum, the gate_sel encoding, and the scale-constant table {1000,100,10,1}.
REQ-031 G SHALL be derived from CLK_HZ within the block.
REQ-032 One sub-module, sync_edge_det (2-flop synchroniser plus rising-edge pulse), SHALL be instantiated; everything else SHALL be flat.

Verification (CLK_HZ=10_000, so the 1 ms gate is 10 cycles)
REQ-033 gate_sel=0, run=1, sig_in period 2 cycles -> 5 events per window, freq=5000, freq_upd every 10 cycles, freq_en=1 after the first window.
REQ-034 gate_sel=3, sig_in period 10 cycles -> freq=1000 after 10000 cycles; update lands 2 cycles after the terminal cycle.
REQ-035 sig_in edge placed exactly on the terminal cycle -> counted in the ending window (count 6, not 5); next window starts the following cycle.
REQ-036 run dropped mid-window -> no freq_upd, freq holds the prior value, busy=0 the next cycle.
REQ-037 gate_sel changed 0->1 mid-window -> freq_en=0, no update, next update after 100 cycles with scale x100.
REQ-038 reset_reset pulsed mid-window -> all outputs 0, and the first update arrives a full G + 2 cycles after release.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated-window frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GATE
    } state_e;

    typedef enum logic [1:0] {
        GATE_1MS   = 2'd0,
        GATE_10MS  = 2'd1,
        GATE_100MS = 2'd2,
        GATE_1S    = 2'd3
    } gate_sel_e;

    localparam int SCALE_W = 10;

    // Hz represented by one counted event, indexed by gate_sel_e.
    localparam logic [SCALE_W-1:0] SCALE_TAB [4] = '{10'd1000, 10'd100, 10'd10, 10'd1};

endpackage

// File: rtl/freq_gate_ctrl_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            meta_p0 <= din;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gated-window frequency meter: counts sig_in edges over 1 ms..1 s windows and reports Hz.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        sig_in,
    input  logic        run,
    input  logic [1:0]  gate_sel,
    output logic [31:0] freq,
    output logic        freq_en,
    output logic        freq_upd,
    output logic        busy
);
    localparam logic [31:0] G_MS = 32'(CLK_HZ / 1000);

    function automatic logic [31:0] gate_len(input gate_sel_e s);
        case (s)
            GATE_1MS:   return G_MS;
            GATE_10MS:  return G_MS * 32'd10;
            GATE_100MS: return G_MS * 32'd100;
            default:    return G_MS * 32'd1000;
        endcase
    endfunction

    // Constant scale applied as a sum of shifted copies of the count.
    function automatic logic [31:0] scale_mult(input logic [31:0] r, input gate_sel_e s);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < SCALE_W; i++) begin
            if (SCALE_TAB[s][i]) acc = acc + (r << i);
        end
        return acc;
    endfunction

    state_e      state, state_nxt;
    gate_sel_e   sel_now, sel_q, sel_win, sel_win_nxt, sel_p0;
    logic [31:0] gate_cnt, gate_cnt_nxt;
    logic [31:0] ev_cnt, ev_cnt_nxt, ev_sum;
    logic [31:0] raw_p0;
    logic        vld_p0;
    logic        ev, sel_chg, latch, publish;

    sync_edge_det u_sync (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .din   (sig_in),
        .pulse (ev)
    );

    assign sel_now = gate_sel_e'(gate_sel);
    assign sel_chg = (sel_now != sel_q);
    assign ev_sum  = ev_cnt + {31'd0, ev};
    assign publish = vld_p0 & ~sel_chg;
    assign busy    = (state == ST_GATE);

    always_comb begin
        state_nxt    = state;
        gate_cnt_nxt = gate_cnt;
        ev_cnt_nxt   = ev_cnt;
        sel_win_nxt  = sel_win;
        latch        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt    = ST_GATE;
                    gate_cnt_nxt = gate_len(sel_now) - 32'd1;
                    ev_cnt_nxt   = '0;
                    sel_win_nxt  = sel_now;
                end
            end
            default: begin
                if (!run) begin
                    state_nxt    = ST_IDLE;
                    gate_cnt_nxt = '0;
                    ev_cnt_nxt   = '0;
                end else if (sel_chg || gate_cnt == 32'd0) begin
                    // A gate_sel change beats the terminal cycle: restart without latching.
                    latch        = ~sel_chg;
                    gate_cnt_nxt = gate_len(sel_now) - 32'd1;
                    ev_cnt_nxt   = '0;
                    sel_win_nxt  = sel_now;
                end else begin
                    gate_cnt_nxt = gate_cnt - 32'd1;
                    ev_cnt_nxt   = ev_sum;
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
            ev_cnt   <= '0;
            sel_win  <= GATE_1MS;
            sel_q    <= GATE_1MS;
            raw_p0   <= '0;
            sel_p0   <= GATE_1MS;
            vld_p0   <= 1'b0;
            freq     <= '0;
            freq_en  <= 1'b0;
            freq_upd <= 1'b0;
        end else begin
            state    <= state_nxt;
            gate_cnt <= gate_cnt_nxt;
            ev_cnt   <= ev_cnt_nxt;
            sel_win  <= sel_win_nxt;
            sel_q    <= sel_now;
            // stage p0: closed window count and the scale it was measured with
            vld_p0   <= latch;
            if (latch) begin
                raw_p0 <= ev_sum;
                sel_p0 <= sel_win;
            end
            // stage p1: scaled result published
            freq_upd <= publish;
            if (publish) freq <= scale_mult(raw_p0, sel_p0);
            if (sel_chg) freq_en <= 1'b0;
            else if (vld_p0) freq_en <= 1'b1;
        end
    end

endmodule
